lsu: RTL and testbench

LSU -- requirements
Module: lsu

---
 rtl/lsu.sv | 192 +++++++++++++++++++
 tb/tb_lsu.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
// Load/store unit for an RV32I core: turns one core load/store into a single
// word-aligned memory transaction, formats load data, and flags misaligned or
// illegal accesses. One access is in flight at a time; the core is stalled
// until the response (or fault) cycle.
module lsu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        fault,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        DONE,
        ERR
    } state_t;

    state_t      state_q, state_d;
    logic        memWe_q, memWe_d;
    logic [3:0]  memBe_q, memBe_d;
    logic [31:0] memAddr_q, memAddr_d;
    logic [31:0] memWdata_q, memWdata_d;
    logic [31:0] rspRdata_q, rspRdata_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  addrLo_q, addrLo_d;

    logic        illegal;
    logic        misaligned;
    logic        accessOk;
    logic [3:0]  reqBe;
    logic [31:0] reqWdata;
    logic [7:0]  loadByte;
    logic [15:0] loadHalf;
    logic [31:0] loadData;

    // Decode the incoming request: legality, alignment, lane mask and replicated store data
    always_comb begin
        illegal    = 1'b0;
        misaligned = 1'b0;
        reqBe      = 4'b0000;
        reqWdata   = 32'h0;
        case (req_funct3)
            3'b000, 3'b100: begin
                reqBe    = 4'b0001 << req_addr[1:0];
                reqWdata = {4{req_wdata[7:0]}};
            end
            3'b001, 3'b101: begin
                reqBe      = req_addr[1] ? 4'b1100 : 4'b0011;
                reqWdata   = {2{req_wdata[15:0]}};
                misaligned = req_addr[0];
            end
            3'b010: begin
                reqBe      = 4'b1111;
                reqWdata   = req_wdata;
                misaligned = (req_addr[1:0] != 2'b00);
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
        // Unsigned widths exist only for loads
        if (req_we && req_funct3[2]) begin
            illegal = 1'b1;
        end
    end

    assign accessOk = !illegal && !misaligned;

    // Pick the addressed byte/half out of the returned word and extend it
    always_comb begin
        case (addrLo_q)
            2'b00:   loadByte = mem_rdata[7:0];
            2'b01:   loadByte = mem_rdata[15:8];
            2'b10:   loadByte = mem_rdata[23:16];
            default: loadByte = mem_rdata[31:24];
        endcase
        loadHalf = addrLo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3_q)
            3'b000:  loadData = {{24{loadByte[7]}}, loadByte};
            3'b100:  loadData = {24'h0, loadByte};
            3'b001:  loadData = {{16{loadHalf[15]}}, loadHalf};
            3'b101:  loadData = {16'h0, loadHalf};
            default: loadData = mem_rdata;
        endcase
    end

    // Next-state logic of the access sequencer
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = accessOk ? REQ : ERR;
                end
            end
            REQ: begin
                if (mem_ready) begin
                    state_d = memWe_q ? DONE : WAIT;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the captured request fields and the load result
    always_comb begin
        memWe_d    = memWe_q;
        memBe_d    = memBe_q;
        memAddr_d  = memAddr_q;
        memWdata_d = memWdata_q;
        rspRdata_d = rspRdata_q;
        funct3_d   = funct3_q;
        addrLo_d   = addrLo_q;
        if (state_q == IDLE && req_valid && accessOk) begin
            memWe_d    = req_we;
            memBe_d    = reqBe;
            memAddr_d  = {req_addr[31:2], 2'b00};
            memWdata_d = req_we ? reqWdata : 32'h0;
            rspRdata_d = 32'h0;
            funct3_d   = req_funct3;
            addrLo_d   = req_addr[1:0];
        end
        if (state_q == WAIT && mem_rvalid) begin
            rspRdata_d = loadData;
        end
    end

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request/response registers, cleared by reset so an abandoned access leaves nothing behind
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            memWe_q    <= 1'b0;
            memBe_q    <= 4'b0000;
            memAddr_q  <= 32'h0;
            memWdata_q <= 32'h0;
            rspRdata_q <= 32'h0;
            funct3_q   <= 3'b000;
            addrLo_q   <= 2'b00;
        end else begin
            memWe_q    <= memWe_d;
            memBe_q    <= memBe_d;
            memAddr_q  <= memAddr_d;
            memWdata_q <= memWdata_d;
            rspRdata_q <= rspRdata_d;
            funct3_q   <= funct3_d;
            addrLo_q   <= addrLo_d;
        end
    end

    assign stall     = (state_q == IDLE && req_valid) || (state_q == REQ) || (state_q == WAIT);
    assign mem_req   = (state_q == REQ);
    assign rsp_valid = (state_q == DONE);
    assign fault     = (state_q == ERR);
    assign mem_we    = memWe_q;
    assign mem_be    = memBe_q;
    assign mem_addr  = memAddr_q;
    assign mem_wdata = memWdata_q;
    assign rsp_rdata = rspRdata_q;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed loads/stores against a small memory
// responder, with expected responses queued as each access is issued and
// popped whenever the unit reports a response or a fault.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        fault;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    typedef struct {
        bit          isFault;
        logic [31:0] rdata;
    } expT;

    expT         expQ[$];
    int          total = 0;
    int          bad = 0;
    int          cycleCnt = 0;
    int          strayCycle = -1;
    bit          autoRvalid = 1'b1;
    logic [31:0] memData = 32'h0;
    int          acceptCount = 0;
    int          rspCount = 0;

    logic        sStall, sRsp, sFault, sMemReq, sMemWe;
    logic [3:0]  sBe;
    logic [31:0] sAddr, sWdata, sRdata;

    int          stallCycles, reqCycles, doneIdx;
    logic [3:0]  capBe;
    logic [31:0] capAddr, capWdata;
    logic        capWe;

    lsu dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .stall      (stall),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .fault      (fault),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_be     (mem_be),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    // Free-running clock, 10 time units per cycle
    always #5 clk = ~clk;

    // Memory responder: answers an accepted load one cycle later, and can inject a stray rvalid
    initial begin
        logic acc;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        forever begin
            @(posedge clk);
            cycleCnt++;
            acc = mem_req && mem_ready && !mem_we;
            #1;
            mem_rvalid = (acc && autoRvalid) || (cycleCnt == strayCycle);
            mem_rdata  = memData;
        end
    end

    // Hard stop in case the sequence itself wedges
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // One comparison: counts it, and on a miss counts the failure and reports it
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Advance one cycle: sample mid-cycle, retire scoreboard entries, then return just after the next edge
    task automatic tick();
        expT e;
        #4;
        sStall  = stall;
        sRsp    = rsp_valid;
        sFault  = fault;
        sMemReq = mem_req;
        sMemWe  = mem_we;
        sBe     = mem_be;
        sAddr   = mem_addr;
        sWdata  = mem_wdata;
        sRdata  = rsp_rdata;
        if (mem_req && mem_ready) acceptCount++;
        if (rsp_valid || fault) begin
            rspCount++;
            checkOutput("sb_nonempty", {31'h0, expQ.size() != 0}, 32'h1);
            if (expQ.size() != 0) begin
                e = expQ.pop_front();
                checkOutput("sb_fault", {31'h0, fault}, {31'h0, e.isFault});
                if (!e.isFault) checkOutput("sb_rdata", rsp_rdata, e.rdata);
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Present one access, play mem_ready, and measure stall/request/response timing
    task automatic applyStimulus(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] rdata, input int readyLow,
                                 input bit expFault, input logic [31:0] expRdata, input bit holdAfter);
        expT e;
        int  lowLeft;
        e.isFault = expFault;
        e.rdata   = expRdata;
        expQ.push_back(e);
        memData    = rdata;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        req_valid  = 1'b1;
        lowLeft    = readyLow;
        mem_ready  = (lowLeft == 0);
        stallCycles = 0;
        reqCycles   = 0;
        doneIdx     = -1;
        capBe       = 4'h0;
        capAddr     = 32'h0;
        capWdata    = 32'h0;
        capWe       = 1'b0;
        for (int c = 0; c < 20 && doneIdx < 0; c++) begin
            tick();
            if (sStall) stallCycles++;
            if (sMemReq) begin
                reqCycles++;
                capBe    = sBe;
                capAddr  = sAddr;
                capWdata = sWdata;
                capWe    = sMemWe;
                if (lowLeft > 0) lowLeft--;
            end
            mem_ready = (lowLeft == 0);
            if (sRsp || sFault) doneIdx = c;
        end
        checkOutput("done_seen", {31'h0, doneIdx >= 0}, 32'h1);
        if (!holdAfter) req_valid = 1'b0;
    endtask

    initial begin
        int acc0, rsp0;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        mem_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        tick();
        checkOutput("rst_mem_req", {31'h0, sMemReq}, 32'h0);
        checkOutput("rst_mem_we", {31'h0, sMemWe}, 32'h0);
        checkOutput("rst_mem_be", {28'h0, sBe}, 32'h0);
        checkOutput("rst_mem_addr", sAddr, 32'h0);
        checkOutput("rst_mem_wdata", sWdata, 32'h0);
        checkOutput("rst_rsp_valid", {31'h0, sRsp}, 32'h0);
        checkOutput("rst_rsp_rdata", sRdata, 32'h0);
        checkOutput("rst_fault", {31'h0, sFault}, 32'h0);
        checkOutput("rst_stall", {31'h0, sStall}, 32'h0);
        req_valid = 1'b1;
        tick();
        checkOutput("rst_stall_follows_req", {31'h0, sStall}, 32'h1);
        req_valid = 1'b0;
        rst_n     = 1'b1;
        tick();

        // LW 0x100
        applyStimulus(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1'b0, 32'hDEADBEEF, 1'b0);
        checkOutput("lw_stall", stallCycles, 3);
        checkOutput("lw_done_idx", doneIdx, 3);
        checkOutput("lw_req_cycles", reqCycles, 1);
        checkOutput("lw_addr", capAddr, 32'h100);
        checkOutput("lw_be", {28'h0, capBe}, 32'hF);
        checkOutput("lw_we", {31'h0, capWe}, 32'h0);
        tick();
        checkOutput("lw_rsp_pulse", {31'h0, sRsp}, 32'h0);
        checkOutput("lw_idle_stall", {31'h0, sStall}, 32'h0);

        // Sub-word loads with sign and zero extension
        applyStimulus(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FFFFFF, 0, 1'b0, 32'hFFFFFF80, 1'b0);
        checkOutput("lb_be", {28'h0, capBe}, 32'h8);
        checkOutput("lb_addr", capAddr, 32'h100);
        applyStimulus(1'b0, 3'b100, 32'h103, 32'h0, 32'h80FFFFFF, 0, 1'b0, 32'h00000080, 1'b0);
        applyStimulus(1'b0, 3'b101, 32'h102, 32'h0, 32'h80010000, 0, 1'b0, 32'h00008001, 1'b0);
        checkOutput("lhu_be", {28'h0, capBe}, 32'hC);
        applyStimulus(1'b0, 3'b001, 32'h102, 32'h0, 32'h80010000, 0, 1'b0, 32'hFFFF8001, 1'b0);
        applyStimulus(1'b0, 3'b000, 32'h101, 32'h0, 32'h00007F00, 0, 1'b0, 32'h0000007F, 1'b0);
        checkOutput("lb1_be", {28'h0, capBe}, 32'h2);

        // SB with mem_ready held low for three request cycles
        applyStimulus(1'b1, 3'b000, 32'h201, 32'h123456AB, 32'h0, 3, 1'b0, 32'h0, 1'b0);
        checkOutput("sb_req_cycles", reqCycles, 4);
        checkOutput("sb_be", {28'h0, capBe}, 32'h2);
        checkOutput("sb_wdata", capWdata, 32'hABABABAB);
        checkOutput("sb_addr", capAddr, 32'h200);
        checkOutput("sb_we", {31'h0, capWe}, 32'h1);
        checkOutput("sb_done_idx", doneIdx, 5);

        // SH, immediate accept
        applyStimulus(1'b1, 3'b001, 32'h202, 32'h0000BEEF, 32'h0, 0, 1'b0, 32'h0, 1'b0);
        checkOutput("sh_stall", stallCycles, 2);
        checkOutput("sh_done_idx", doneIdx, 2);
        checkOutput("sh_be", {28'h0, capBe}, 32'hC);
        checkOutput("sh_wdata", capWdata, 32'hBEEFBEEF);

        // Faults: misaligned LH, misaligned SW, reserved funct3, store with unsigned width
        applyStimulus(1'b0, 3'b001, 32'h101, 32'h0, 32'h0, 0, 1'b1, 32'h0, 1'b0);
        checkOutput("lh_mis_idx", doneIdx, 1);
        checkOutput("lh_mis_req", reqCycles, 0);
        tick();
        checkOutput("lh_mis_pulse", {31'h0, sFault}, 32'h0);
        applyStimulus(1'b1, 3'b010, 32'h102, 32'h11111111, 32'h0, 0, 1'b1, 32'h0, 1'b0);
        checkOutput("sw_mis_idx", doneIdx, 1);
        checkOutput("sw_mis_req", reqCycles, 0);
        applyStimulus(1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 0, 1'b1, 32'h0, 1'b0);
        checkOutput("f3_011_idx", doneIdx, 1);
        checkOutput("f3_011_req", reqCycles, 0);
        applyStimulus(1'b1, 3'b100, 32'h100, 32'h0, 32'h0, 0, 1'b1, 32'h0, 1'b0);
        checkOutput("sbu_req", reqCycles, 0);
        tick();

        // Reset while waiting for load data, then a stray rvalid
        autoRvalid = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h100;
        req_valid  = 1'b1;
        mem_ready  = 1'b1;
        rsp0       = rspCount;
        tick();
        tick();
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        strayCycle = cycleCnt + 1;
        tick();
        checkOutput("wait_stall", {31'h0, sStall}, 32'h1);
        checkOutput("wait_no_req", {31'h0, sMemReq}, 32'h0);
        rst_n = 1'b1;
        tick();
        checkOutput("abandon_mem_req", {31'h0, sMemReq}, 32'h0);
        checkOutput("abandon_mem_we", {31'h0, sMemWe}, 32'h0);
        checkOutput("abandon_mem_be", {28'h0, sBe}, 32'h0);
        checkOutput("abandon_mem_addr", sAddr, 32'h0);
        checkOutput("abandon_rsp_rdata", sRdata, 32'h0);
        checkOutput("abandon_stall", {31'h0, sStall}, 32'h0);
        tick();
        checkOutput("abandon_no_rsp", rspCount - rsp0, 0);
        autoRvalid = 1'b1;
        applyStimulus(1'b0, 3'b010, 32'h100, 32'h0, 32'h0BADF00D, 0, 1'b0, 32'h0BADF00D, 1'b0);
        checkOutput("post_rst_lw_stall", stallCycles, 3);

        // Back-to-back SW then LW with req_valid held through DONE
        tick();
        acc0 = acceptCount;
        rsp0 = rspCount;
        applyStimulus(1'b1, 3'b010, 32'h300, 32'hCAFEF00D, 32'h0, 0, 1'b0, 32'h0, 1'b1);
        checkOutput("b2b_sw_wdata", capWdata, 32'hCAFEF00D);
        applyStimulus(1'b0, 3'b010, 32'h304, 32'h0, 32'h11223344, 0, 1'b0, 32'h11223344, 1'b0);
        checkOutput("b2b_lw_stall", stallCycles, 3);
        checkOutput("b2b_lw_addr", capAddr, 32'h304);
        tick();
        tick();
        checkOutput("b2b_accepts", acceptCount - acc0, 2);
        checkOutput("b2b_rsps", rspCount - rsp0, 2);
        checkOutput("sb_drained", expQ.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
